// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data SRAM responder: config window
// location, register offsets inside the window, and the byte-lane merge.
package data_sram_resp_pkg;

    localparam logic [15:0] DEF_CONF_HI = 16'hbfaf;

    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_NUM    = 16'hf010;
    localparam logic [15:0] OFF_SWITCH = 16'hf020;
    localparam logic [15:0] OFF_TIMER  = 16'he000;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  wen
    );
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/confreg_regs.sv
// Config-window registers (LED, NUM, SWITCH readback, optional TIMER) and the
// window read mux. TIMER is built only when DATA_SRAM_RESP_TIMER_EN is defined.
module confreg_regs
    import data_sram_resp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic [3:0]  i_wen,
    input  logic [15:0] i_off,
    input  logic [31:0] i_wdata,
    input  logic [7:0]  i_switch,
    output logic [31:0] o_rdata,
    output logic [15:0] o_led,
    output logic [31:0] o_num
);

    logic [15:0] r_led;
    logic [31:0] r_num;
    logic        w_wr;

    assign w_wr = i_en && (i_wen != 4'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led <= 16'h0;
            r_num <= 32'h0;
        end else if (w_wr) begin
            if (i_off == OFF_LED) begin
                if (i_wen[0]) r_led[7:0]  <= i_wdata[7:0];
                if (i_wen[1]) r_led[15:8] <= i_wdata[15:8];
            end
            if (i_off == OFF_NUM) begin
                r_num <= byte_merge(r_num, i_wdata, i_wen);
            end
        end
    end

`ifdef DATA_SRAM_RESP_TIMER_EN
    logic [31:0] r_timer;

    // A write cycle loads the merged value instead of counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 32'h0;
        end else if (w_wr && (i_off == OFF_TIMER)) begin
            r_timer <= byte_merge(r_timer, i_wdata, i_wen);
        end else begin
            r_timer <= r_timer + 32'h1;
        end
    end
`endif

    always_comb begin
        o_rdata = 32'h0;
        case (i_off)
            OFF_LED:    o_rdata = {16'h0, r_led};
            OFF_NUM:    o_rdata = r_num;
            OFF_SWITCH: o_rdata = {24'h0, i_switch};
`ifdef DATA_SRAM_RESP_TIMER_EN
            OFF_TIMER:  o_rdata = r_timer;
`endif
            default:    o_rdata = 32'h0;
        endcase
    end

    assign o_led = r_led;
    assign o_num = r_num;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: decodes each request to the byte-writable RAM or the
// config window and registers the pre-write word. Optional: DATA_SRAM_RESP_TIMER_EN.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          RAM_AW  = 14,
    parameter logic [15:0] CONF_HI = DEF_CONF_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    localparam int RAM_DEPTH = 2 ** RAM_AW;

    logic [31:0]       r_ram [RAM_DEPTH];
    logic [31:0]       r_rdata;
    logic              w_sel_conf;
    logic [RAM_AW-1:0] w_idx;
    logic [31:0]       w_ram_rdata;
    logic [31:0]       w_conf_rdata;
    logic              w_ram_we;
    logic [1:0]        w_unused_addr;

    assign w_sel_conf    = (data_sram_addr[31:16] == CONF_HI);
    assign w_idx         = data_sram_addr[RAM_AW+1:2];
    assign w_ram_rdata   = r_ram[w_idx];
    assign w_unused_addr = data_sram_addr[1:0];
    assign w_ram_we      = !reset && data_sram_en && !w_sel_conf && (data_sram_wen != 4'h0);

    // RAM contents survive reset; only the write itself is gated.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_idx] <= byte_merge(w_ram_rdata, data_sram_wdata, data_sram_wen);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0;
        end else if (data_sram_en) begin
            r_rdata <= w_sel_conf ? w_conf_rdata : w_ram_rdata;
        end
    end

    confreg_regs u_confreg (
        .clk      (clk),
        .reset    (reset),
        .i_en     (data_sram_en && w_sel_conf),
        .i_wen    (data_sram_wen),
        .i_off    (data_sram_addr[15:0]),
        .i_wdata  (data_sram_wdata),
        .i_switch (switch),
        .o_rdata  (w_conf_rdata),
        .o_led    (led),
        .o_num    (num_data)
    );

    assign data_sram_rdata = r_rdata;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed and random bench for data_sram_resp against a word/byte-level
// reference model of the responder's memory map.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  sw;
    logic [15:0] led;
    logic [31:0] num_data;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m_ram [int];
    logic [15:0] m_led;
    logic [31:0] m_num;
    logic [31:0] m_timer;
    logic [31:0] m_rdata;
    int          pool [8];

    always #5 clk = ~clk;

    data_sram_resp dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch          (sw),
        .led             (led),
        .num_data        (num_data)
    );

    function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] we);
        logic [31:0] mask;
        mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic logic [31:0] cfg_read(input logic [15:0] off);
        if (off == 16'hf000) return {16'h0, m_led};
        if (off == 16'hf010) return m_num;
        if (off == 16'hf020) return {24'h0, sw};
`ifdef DATA_SRAM_RESP_TIMER_EN
        if (off == 16'he000) return m_timer;
`endif
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input bit r, input bit e, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] d);
        logic [31:0] t_next;
        logic [31:0] tmp;
        int          idx;
        reset = r; en = e; wen = we; addr = a; wdata = d;
        if (r) begin
            m_rdata = 32'h0; m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0;
        end else begin
            t_next = m_timer + 32'h1;
            if (e) begin
                idx = int'(a[15:2]);
                if (a[31:16] == 16'hbfaf) begin
                    m_rdata = cfg_read(a[15:0]);
                    if (we != 4'h0) begin
                        if (a[15:0] == 16'hf000) begin
                            tmp = mmerge({16'h0, m_led}, d, we);
                            m_led = tmp[15:0];
                        end
                        if (a[15:0] == 16'hf010) m_num = mmerge(m_num, d, we);
`ifdef DATA_SRAM_RESP_TIMER_EN
                        if (a[15:0] == 16'he000) t_next = mmerge(m_timer, d, we);
`endif
                    end
                end else begin
                    m_rdata = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
                    if (we != 4'h0) m_ram[idx] = mmerge(m_rdata, d, we);
                end
            end
            m_timer = t_next;
        end
        @(posedge clk);
        #1;
        chk("rdata", rdata, m_rdata);
        chk("led", {16'h0, led}, {16'h0, m_led});
        chk("num", num_data, m_num);
    endtask

    initial begin
        logic [31:0] hold;
        logic [31:0] hi;
        int          k;
        int          r;
        logic [15:0] offs [5];
        offs[0] = 16'hf000; offs[1] = 16'hf010; offs[2] = 16'hf020;
        offs[3] = 16'he000; offs[4] = 16'h1234;
        m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0; m_rdata = 32'h0;
        sw = 8'h00;
        reset = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        @(negedge clk);

        cyc(1, 0, 4'h0, 32'h0, 32'h0);
        cyc(1, 0, 4'h0, 32'h0, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_num", num_data, 32'h0);

        cyc(0, 1, 4'hf, 32'h00000010, 32'hdeadbeef);
        cyc(0, 1, 4'h0, 32'h00000010, 32'h0);
        chk("ram_rd", rdata, 32'hdeadbeef);

        cyc(0, 1, 4'hf, 32'h00000020, 32'haaaaaaaa);
        cyc(0, 1, 4'h5, 32'h00000020, 32'h11223344);
        cyc(0, 1, 4'h0, 32'h00000020, 32'h0);
        chk("ram_part", rdata, 32'haa22aa44);

        cyc(0, 1, 4'hf, 32'h00000010, 32'h55555555);
        chk("ram_old_on_wr", rdata, 32'hdeadbeef);

        cyc(0, 1, 4'hf, 32'hbfaff000, 32'h0001abcd);
        chk("led_wr", {16'h0, led}, 32'h0000abcd);
        cyc(0, 1, 4'h0, 32'hbfaff000, 32'h0);
        chk("led_rd", rdata, 32'h0000abcd);
        sw = 8'h5a;
        cyc(0, 1, 4'h0, 32'hbfaff020, 32'h0);
        chk("sw_rd", rdata, 32'h0000005a);
        cyc(0, 1, 4'hf, 32'hbfaff020, 32'hffffffff);

        cyc(0, 1, 4'hf, 32'hbfafe000, 32'hfffffffe);
        cyc(0, 0, 4'h0, 32'h0, 32'h0);
        cyc(0, 1, 4'h0, 32'hbfafe000, 32'h0);
`ifdef DATA_SRAM_RESP_TIMER_EN
        chk("tmr0", rdata, 32'hffffffff);
`else
        chk("tmr0", rdata, 32'h0);
`endif
        cyc(0, 1, 4'h0, 32'hbfafe000, 32'h0);
        chk("tmr1", rdata, 32'h0);
        cyc(0, 1, 4'h0, 32'hbfafe000, 32'h0);
`ifdef DATA_SRAM_RESP_TIMER_EN
        chk("tmr2", rdata, 32'h00000001);
`else
        chk("tmr2", rdata, 32'h0);
`endif

        cyc(0, 1, 4'hf, 32'hbfaff010, 32'h12345678);
        chk("num_wr", num_data, 32'h12345678);
        cyc(0, 1, 4'h0, 32'h00000010, 32'h0);
        cyc(1, 1, 4'hf, 32'hbfaff010, 32'hcafef00d);
        chk("rst_mid_num", num_data, 32'h0);
        chk("rst_mid_rdata", rdata, 32'h0);

        cyc(0, 1, 4'h0, 32'h00000010, 32'h0);
        chk("ram_kept", rdata, 32'h55555555);
        cyc(0, 1, 4'h0, 32'hbfaf1234, 32'h0);
        chk("unmapped", rdata, 32'h0);
        cyc(0, 1, 4'h0, 32'h00000020, 32'h0);
        hold = rdata;
        for (int i = 0; i < 5; i++) cyc(0, 0, 4'hf, 32'h00000020, 32'h0);
        chk("idle_hold", rdata, 32'haa22aa44);
        chk("idle_same", rdata, hold);

        for (int i = 0; i < 8; i++) begin
            pool[i] = int'($urandom_range(0, 16383));
            cyc(0, 1, 4'hf, {16'h0, pool[i][13:0], 2'b00}, $urandom);
        end
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            sw = 8'($urandom);
            hi = $urandom;
            if (hi[31:16] == 16'hbfaf) hi[31:16] = 16'h0;
            k = int'($urandom_range(0, 7));
            if (r < 3) begin
                cyc(1, 1, 4'($urandom), 32'hbfaff010, $urandom);
            end else if (r < 15) begin
                cyc(0, 0, 4'($urandom), {16'hbfaf, offs[k % 5]}, $urandom);
            end else if (r < 60) begin
                cyc(0, 1, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                    {hi[31:16], pool[k][13:0], 2'($urandom)}, $urandom);
            end else begin
                cyc(0, 1, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                    {16'hbfaf, offs[k % 5]}, $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
